// File: rtl/sto_peak_detector.sv
// Symbol timing offset peak detector: tracks the strongest timing metric across OFDM symbols
// and reports its in-symbol index and symbol number. Optional threshold check: STO_THRESH_EN.
module sto_peak_detector #(
    parameter int unsigned MW      = 16,
    parameter int unsigned IW      = 6,
    parameter int unsigned SYM_LEN = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          metric_valid,
    input  logic [MW-1:0] metric,
    input  logic          sym_last,
    input  logic          calc_en,
    output logic [IW-1:0] sto_est,
    output logic [7:0]    sto_sym,
    output logic [MW-1:0] peak_val,
    output logic          sto_valid,
    output logic          sto_miss,
    output logic          busy
`ifdef STO_THRESH_EN
    ,
    input  logic [MW-1:0] thresh
`endif
);

    typedef enum logic [1:0] {IDLE, SEARCH, REPORT} state_t;

    state_t        state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [7:0]    sym_cnt, sym_cnt_n;
    logic [MW-1:0] best_val, best_val_n;
    logic [IW-1:0] best_idx, best_idx_n;
    logic [7:0]    best_sym, best_sym_n;
    logic [IW-1:0] sto_est_n;
    logic [7:0]    sto_sym_n;
    logic [MW-1:0] peak_val_n;
    logic          sto_valid_n, sto_miss_n, busy_n;

    // Best-so-far including the current sample, so a sample arriving with calc_en is reported
    logic          take;
    logic [MW-1:0] cand_val;
    logic [IW-1:0] cand_idx;
    logic [7:0]    cand_sym;

    assign take     = metric_valid && (metric > best_val);
    assign cand_val = take ? metric  : best_val;
    assign cand_idx = take ? idx     : best_idx;
    assign cand_sym = take ? sym_cnt : best_sym;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = SEARCH;
            SEARCH:  if (!start && calc_en) state_n = REPORT;
            REPORT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        idx_n       = idx;
        sym_cnt_n   = sym_cnt;
        best_val_n  = best_val;
        best_idx_n  = best_idx;
        best_sym_n  = best_sym;
        sto_est_n   = sto_est;
        sto_sym_n   = sto_sym;
        peak_val_n  = peak_val;
        sto_valid_n = 1'b0;
        sto_miss_n  = sto_miss;
        busy_n      = (state_n != IDLE);
        if ((state == IDLE || state == SEARCH) && start) begin
            idx_n      = '0;
            sym_cnt_n  = '0;
            best_val_n = '0;
            best_idx_n = '0;
            best_sym_n = '0;
        end else if (state == SEARCH) begin
            if (metric_valid) begin
                best_val_n = cand_val;
                best_idx_n = cand_idx;
                best_sym_n = cand_sym;
                // Symbol closes on sym_last or on the last index, whichever comes first
                if (sym_last || idx == IW'(SYM_LEN - 1)) idx_n = '0;
                else                                     idx_n = idx + IW'(1);
                if (sym_last && sym_cnt != 8'hFF) sym_cnt_n = sym_cnt + 8'd1;
            end
            if (calc_en) begin
                sto_est_n   = cand_idx;
                sto_sym_n   = cand_sym;
                peak_val_n  = cand_val;
                sto_valid_n = 1'b1;
`ifdef STO_THRESH_EN
                sto_miss_n  = (cand_val < thresh);
`else
                sto_miss_n  = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx       <= '0;
            sym_cnt   <= '0;
            best_val  <= '0;
            best_idx  <= '0;
            best_sym  <= '0;
            sto_est   <= '0;
            sto_sym   <= '0;
            peak_val  <= '0;
            sto_valid <= 1'b0;
            sto_miss  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            idx       <= idx_n;
            sym_cnt   <= sym_cnt_n;
            best_val  <= best_val_n;
            best_idx  <= best_idx_n;
            best_sym  <= best_sym_n;
            sto_est   <= sto_est_n;
            sto_sym   <= sto_sym_n;
            peak_val  <= peak_val_n;
            sto_valid <= sto_valid_n;
            sto_miss  <= sto_miss_n;
            busy      <= busy_n;
        end
    end

endmodule

// File: doc/sto_peak_detector.md
STO_PEAK_DETECTOR -- requirements
Module: sto_peak_detector

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: MW, 16, metric width, unsigned; IW, 6, in-symbol index width; SYM_LEN, 64, samples per OFDM symbol, at most 2^IW.
REQ-002 Ports SHALL be, in order (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low.
- start  in  1  clears the search and enters SEARCH.
- metric_valid  in  1  metric sample strobe.
- metric  in  MW  matched-filter timing metric.
- sym_last  in  1  qualifies the current valid sample as the last sample of a symbol.
- calc_en  in  1  requests the final estimate.
- sto_est  out  IW  in-symbol index of the best peak.
- sto_sym  out  8  symbol number holding the best peak.
- peak_val  out  MW  best metric value.
- sto_valid  out  1  one-cycle result strobe.
- sto_miss  out  1  peak below threshold, qualified by sto_valid.
- busy  out  1  high in SEARCH and REPORT.

Function
REQ-003 The FSM SHALL have three states: IDLE, SEARCH and REPORT. All registers SHALL update on the rising edge of clk.
REQ-004 In IDLE, start=1 SHALL clear idx, sym_cnt, best_val, best_idx and best_sym to 0 and move to SEARCH. calc_en, metric_valid and sym_last SHALL be ignored in IDLE.
REQ-005 In SEARCH, each metric_valid=1 sample SHALL be compared with best_val. If metric > best_val (strict), best_val, best_idx and best_sym SHALL load metric, idx and sym_cnt. Ties SHALL keep the earliest sample.
REQ-006 idx SHALL increment on each valid sample. idx SHALL reset to 0 after sample SYM_LEN-1, or after a valid sample with sym_last=1, whichever comes first.
REQ-007 A valid sample with sym_last=1 SHALL increment sym_cnt, saturating at 255. sym_last without metric_valid SHALL be ignored.
REQ-008 The sample that closes a symbol SHALL be compared before the counters change.
REQ-009 In SEARCH, calc_en=1 SHALL move to REPORT. A metric_valid sample in the same cycle SHALL still be included in the search.
REQ-010 In SEARCH, start=1 SHALL restart the search as in REQ-004 and take priority over calc_en and over any sample in that cycle.
REQ-011 When calc_en is sampled high in cycle k, sto_est, sto_sym and peak_val SHALL present the final best values from cycle k+1 and hold them until the next report.
REQ-012 sto_valid SHALL be 1 in cycle k+1 only. The FSM SHALL be in REPORT in cycle k+1 and SHALL return to IDLE in cycle k+2, ignoring all inputs while in REPORT.
REQ-013 If no valid sample was seen before calc_en, the report SHALL be sto_est=0, sto_sym=0, peak_val=0.
REQ-014 busy SHALL equal (state != IDLE).

Reset
REQ-015 With reset=0 at a rising edge, the state SHALL become IDLE. All internal registers and sto_est, sto_sym, peak_val, sto_valid, sto_miss and busy SHALL become 0.
REQ-016 Reset SHALL override start, calc_en and any search or report in progress, and no sto_valid SHALL follow it.

Configuration
REQ-017 Macro STO_THRESH_EN SHALL control threshold checking.
- Defined: an input port thresh, MW bits, SHALL be present. sto_miss SHALL register (best_val < thresh) in the same cycle that sto_valid asserts.
- Undefined: thresh SHALL be absent and sto_miss SHALL be constant 0.

Verification
REQ-018 Basic peak: start, then 64 valid samples of 10 except metric=500 at idx 17, sym_last on sample 63, calc_en one cycle later -> next cycle sto_valid=1, sto_est=17, sto_sym=0, peak_val=500; busy low two cycles after calc_en.
REQ-019 Tie and multi-symbol: symbol 0 peak 300@5, symbol 1 peaks 300@9 and 400@40, symbol 2 peak 350@2 -> sto_est=40, sto_sym=1, peak_val=400.
REQ-020 Simultaneous events: metric=900 at idx 3 in the same cycle as calc_en -> peak_val=900, sto_est=3. start and calc_en together in SEARCH -> no sto_valid, search cleared, busy stays 1.
REQ-021 Reset mid-search: after 30 samples, reset=0 for one cycle -> all outputs 0 and state IDLE. A later calc_en without start -> no sto_valid.
REQ-022 Wrap and edge cases: 130 valid samples with no sym_last and peak at sample 129 -> sto_est=1, sto_sym=0. calc_en with no valid samples -> sto_valid=1 with all results 0.
REQ-023 STO_THRESH_EN defined, thresh=600, peak 500 -> sto_miss=1 with sto_valid. Same run with thresh=400 -> sto_miss=0. Without the macro -> sto_miss=0 always.
